// File: rtl/pipe_hazard_ctrl.sv
// Pipeline control for the 3-stage core: jump/flush arbitration, hold merging and bus-hold jump replay.
// Define PIPE_PERF_CNT_EN to add stall/flush performance counters.
module pipe_hazard_ctrl #(
   parameter int ADDR_W   = 32,
   parameter int MAX_HOLD = 255,
   parameter int CNT_W    = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              ex_jump_flag_i,
   input  logic [ADDR_W-1:0] ex_jump_addr_i,
   input  logic              int_jump_flag_i,
   input  logic [ADDR_W-1:0] int_jump_addr_i,
   input  logic              div_busy_i,
   input  logic              bus_hold_i,
   output logic              jump_flag_o,
   output logic [ADDR_W-1:0] jump_addr_o,
   output logic [2:0]        hold_o,
   output logic              flush_if_id_o,
   output logic              flush_id_ex_o,
`ifdef PIPE_PERF_CNT_EN
   output logic [31:0]       stall_cycles_o,
   output logic [31:0]       flush_events_o,
`endif
   output logic              hold_timeout_o
);

   typedef enum logic {RUN, PEND} state_t;

   // One extra counter bit so the saturation value MAX_HOLD+1 is representable.
   localparam logic [CNT_W:0] HOLD_LIM = (CNT_W+1)'(MAX_HOLD);
   localparam logic [CNT_W:0] HOLD_SAT = (CNT_W+1)'(MAX_HOLD + 1);
   localparam logic [CNT_W:0] CNT_ONE  = (CNT_W+1)'(1);

   state_t              state, state_nxt;
   logic [ADDR_W-1:0]   pend_addr, pend_nxt;
   logic [CNT_W:0]      hold_cnt;
   logic                sel_flag;
   logic [ADDR_W-1:0]   sel_addr;
   logic [2:0]          hold_lvl;

   assign sel_flag = int_jump_flag_i | ex_jump_flag_i;
   assign sel_addr = int_jump_flag_i ? int_jump_addr_i : ex_jump_addr_i;

   always_comb begin
      hold_lvl = 3'd0;
      if (div_busy_i)
         hold_lvl = 3'd3;
      else if (bus_hold_i || state == PEND)
         hold_lvl = 3'd2;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         pend_addr <= '0;
      end else begin
         state     <= state_nxt;
         pend_addr <= pend_nxt;
      end
   end

   // A redirect always wins over any hold level in the cycle it is issued.
   always_comb begin
      state_nxt     = state;
      pend_nxt      = pend_addr;
      jump_flag_o   = 1'b0;
      jump_addr_o   = '0;
      flush_if_id_o = 1'b0;
      flush_id_ex_o = 1'b0;
      hold_o        = 3'd0;
      if (rst) begin
         hold_o = hold_lvl;
         case (state)
            RUN: begin
               if (sel_flag && !bus_hold_i) begin
                  jump_flag_o   = 1'b1;
                  jump_addr_o   = sel_addr;
                  flush_if_id_o = 1'b1;
                  flush_id_ex_o = 1'b1;
                  hold_o        = 3'd0;
               end else if (sel_flag) begin
                  pend_nxt  = sel_addr;
                  state_nxt = PEND;
               end
            end
            PEND: begin
               if (bus_hold_i) begin
                  // Execute is stalled, so only an interrupt may replace the parked jump.
                  if (int_jump_flag_i)
                     pend_nxt = int_jump_addr_i;
               end else begin
                  jump_flag_o   = 1'b1;
                  jump_addr_o   = int_jump_flag_i ? int_jump_addr_i : pend_addr;
                  flush_if_id_o = 1'b1;
                  flush_id_ex_o = 1'b1;
                  hold_o        = 3'd0;
                  state_nxt     = RUN;
               end
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         hold_cnt       <= '0;
         hold_timeout_o <= 1'b0;
      end else if (bus_hold_i) begin
         if (hold_cnt != HOLD_SAT)
            hold_cnt <= hold_cnt + CNT_ONE;
         if (hold_cnt >= HOLD_LIM)
            hold_timeout_o <= 1'b1;
      end else begin
         hold_cnt <= '0;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cycles_o <= '0;
         flush_events_o <= '0;
      end else begin
         if (hold_o != 3'd0)
            stall_cycles_o <= stall_cycles_o + 32'd1;
         if (jump_flag_o)
            flush_events_o <= flush_events_o + 32'd1;
      end
   end
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Scoreboard bench for pipe_hazard_ctrl: driver pushes model expectations, monitor pops and compares.
module tb_pipe_hazard_ctrl;
   localparam int ADDR_W   = 32;
   localparam int MAX_HOLD = 4;
   localparam int CNT_W    = 3;

   logic              clk = 1'b0;
   logic              rst;
   logic              ex_jump_flag_i, int_jump_flag_i, div_busy_i, bus_hold_i;
   logic [ADDR_W-1:0] ex_jump_addr_i, int_jump_addr_i;
   logic              jump_flag_o, flush_if_id_o, flush_id_ex_o, hold_timeout_o;
   logic [ADDR_W-1:0] jump_addr_o;
   logic [2:0]        hold_o;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0]       stall_cycles_o, flush_events_o;
`endif

   pipe_hazard_ctrl #(.ADDR_W(ADDR_W), .MAX_HOLD(MAX_HOLD), .CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst),
      .ex_jump_flag_i(ex_jump_flag_i), .ex_jump_addr_i(ex_jump_addr_i),
      .int_jump_flag_i(int_jump_flag_i), .int_jump_addr_i(int_jump_addr_i),
      .div_busy_i(div_busy_i), .bus_hold_i(bus_hold_i),
      .jump_flag_o(jump_flag_o), .jump_addr_o(jump_addr_o), .hold_o(hold_o),
      .flush_if_id_o(flush_if_id_o), .flush_id_ex_o(flush_id_ex_o),
`ifdef PIPE_PERF_CNT_EN
      .stall_cycles_o(stall_cycles_o), .flush_events_o(flush_events_o),
`endif
      .hold_timeout_o(hold_timeout_o)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        jf;
      logic [31:0] ja;
      logic [2:0]  hold;
      logic        fi;
      logic        fe;
      logic        to;
      logic [31:0] stall;
      logic [31:0] flush;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec  = 0;
   int   n_miss = 0;

   // Reference model state: is a jump parked, its target, length of the current bus-hold run.
   bit          m_pend;
   logic [31:0] m_paddr;
   int          m_run;
   bit          m_to;
   logic [31:0] m_stall, m_flush;

   task automatic apply(input bit r, input bit ex, input logic [31:0] ea,
                        input bit in, input logic [31:0] ia,
                        input bit dv, input bit bs);
      exp_t e;
      @(posedge clk);
      #1;
      rst = r; ex_jump_flag_i = ex; ex_jump_addr_i = ea;
      int_jump_flag_i = in; int_jump_addr_i = ia;
      div_busy_i = dv; bus_hold_i = bs;
      e = '0;
      if (!r) begin
         m_pend = 0; m_paddr = '0; m_run = 0; m_to = 0; m_stall = '0; m_flush = '0;
      end else begin
         bit          want;
         logic [31:0] target;
         logic [2:0]  stall_lvl;
         want      = ex || in;
         target    = in ? ia : ea;
         stall_lvl = dv ? 3'd3 : ((bs || m_pend) ? 3'd2 : 3'd0);
         e.to = m_to; e.stall = m_stall; e.flush = m_flush;
         if (!m_pend && want && !bs) begin
            e.jf = 1; e.ja = target; e.fi = 1; e.fe = 1; e.hold = 3'd0;
         end else if (!m_pend) begin
            e.hold = stall_lvl;
            if (want) begin
               m_pend = 1; m_paddr = target;
            end
         end else if (bs) begin
            e.hold = stall_lvl;
            if (in) m_paddr = ia;
         end else begin
            e.jf = 1; e.ja = in ? ia : m_paddr; e.fi = 1; e.fe = 1; e.hold = 3'd0;
            m_pend = 0;
         end
         if (e.hold != 3'd0) m_stall = m_stall + 32'd1;
         if (e.jf) m_flush = m_flush + 32'd1;
         if (bs) begin
            m_run = m_run + 1;
            if (m_run >= MAX_HOLD + 1) m_to = 1;
         end else begin
            m_run = 0;
         end
      end
      exp_q.push_back(e);
   endtask

   task automatic chk(input string nm, input int v, input logic [31:0] act,
                      input logic [31:0] req, inout bit bad);
      if (act !== req) begin
         $display("FAIL %s vec %0d: got %h required %h", nm, v, act, req);
         bad = 1;
      end
   endtask

   initial begin
      exp_t e;
      bit   bad;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            bad = 0;
            chk("jump_flag", n_vec, {31'd0, jump_flag_o}, {31'd0, e.jf}, bad);
            chk("jump_addr", n_vec, jump_addr_o, e.ja, bad);
            chk("hold", n_vec, {29'd0, hold_o}, {29'd0, e.hold}, bad);
            chk("flush_if_id", n_vec, {31'd0, flush_if_id_o}, {31'd0, e.fi}, bad);
            chk("flush_id_ex", n_vec, {31'd0, flush_id_ex_o}, {31'd0, e.fe}, bad);
            chk("timeout", n_vec, {31'd0, hold_timeout_o}, {31'd0, e.to}, bad);
`ifdef PIPE_PERF_CNT_EN
            chk("stall_cycles", n_vec, stall_cycles_o, e.stall, bad);
            chk("flush_events", n_vec, flush_events_o, e.flush, bad);
`endif
            n_vec++;
            if (bad) n_miss++;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int run_left;
      rst = 0; ex_jump_flag_i = 0; int_jump_flag_i = 0; div_busy_i = 0; bus_hold_i = 0;
      ex_jump_addr_i = '0; int_jump_addr_i = '0;
      apply(0, 0, 0, 0, 0, 0, 0);
      apply(0, 1, 32'h100, 1, 32'h8, 1, 1);
      // 1: plain execute jump
      apply(1, 0, 0, 0, 0, 0, 0);
      apply(1, 1, 32'h100, 0, 0, 0, 0);
      // 2: interrupt beats execute
      apply(1, 1, 32'h200, 1, 32'h8, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0);
      // 3: jump parked during a 4-cycle bus hold
      apply(1, 1, 32'h300, 0, 0, 0, 1);
      for (int i = 0; i < 3; i++) apply(1, 0, 0, 0, 0, 0, 1);
      apply(1, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0);
      // 4: interrupt overwrites the parked jump, later execute jump ignored
      apply(1, 1, 32'h300, 0, 0, 0, 1);
      apply(1, 1, 32'h444, 0, 0, 0, 1);
      apply(1, 0, 0, 1, 32'h10, 0, 1);
      apply(1, 0, 0, 0, 0, 0, 1);
      apply(1, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0);
      // 5: divider hold, alone and with bus hold
      for (int i = 0; i < 10; i++) apply(1, 0, 0, 0, 0, 1, (i >= 6));
      apply(1, 0, 0, 0, 0, 0, 0);
      // replay collides with a fresh interrupt and a divider hold
      apply(1, 1, 32'h500, 0, 0, 1, 1);
      apply(1, 0, 0, 1, 32'h20, 1, 0);
      apply(1, 0, 0, 0, 0, 0, 0);
      // 6: timeout after five hold cycles, sticky, then reset mid-PEND
      for (int i = 0; i < 6; i++) apply(1, 0, 0, 0, 0, 0, 1);
      apply(1, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0);
      apply(1, 1, 32'h600, 0, 0, 0, 1);
      apply(1, 0, 0, 0, 0, 0, 1);
      apply(0, 0, 0, 0, 0, 0, 1);
      apply(1, 0, 0, 0, 0, 0, 1);
      apply(1, 0, 0, 0, 0, 0, 0);
      apply(1, 0, 0, 0, 0, 0, 0);
      // randomized traffic with bursty bus holds
      run_left = 0;
      for (int i = 0; i < 3000; i++) begin
         bit bs;
         if (run_left == 0 && ($urandom % 5) == 0) run_left = $urandom_range(1, 7);
         bs = (run_left > 0);
         if (run_left > 0) run_left--;
         apply(($urandom % 150) != 0,
               ($urandom % 10) < 3, $urandom,
               ($urandom % 10) == 0, $urandom,
               ($urandom % 7) == 0, bs);
      end
      repeat (3) @(posedge clk);
      if (exp_q.size() != 0) begin
         $display("FAIL drain: got %0d pending required 0", exp_q.size());
         n_miss++;
      end
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
Central pipeline control unit for the 3-stage RV32I core. It replaces the pure-combinational jump forwarder with a sequenced controller. It arbitrates jump/flush requests from the interrupt controller and the execute stage, and merges hold requests from the divider and the bus arbiter into one hold level. A jump that arrives during a bus hold is latched and replayed once the hold releases. Outputs drive pc_reg, if_id and id_ex.

Parameters:
- ADDR_W, 32, width of instruction addresses (matches `InstAddrBus`).
- MAX_HOLD, 255, bus-hold cycle limit; exceeding it raises hold_timeout_o.
- CNT_W, 8, width of the bus-hold cycle counter; must satisfy 2^CNT_W > MAX_HOLD.

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous reset, active-low
- ex_jump_flag_i  in  1  branch/jal/jalr taken in execute
- ex_jump_addr_i  in  ADDR_W  execute jump target
- int_jump_flag_i  in  1  interrupt/mret redirect from clint
- int_jump_addr_i  in  ADDR_W  interrupt/mret target
- div_busy_i  in  1  divider multi-cycle busy
- bus_hold_i  in  1  bus arbiter stalls core fetch/access
- jump_flag_o  out  1  redirect pc_reg
- jump_addr_o  out  ADDR_W  redirect target
- hold_o  out  3  hold level: 0 none, 1 pc, 2 pc+if, 3 pc+if+id
- flush_if_id_o  out  1  clear if_id register
- flush_id_ex_o  out  1  clear id_ex register
- hold_timeout_o  out  1  sticky bus-hold timeout

Behaviour:
- Reset (rst=0, async):
  - state=RUN; pend_addr=0; hold_cnt=0; hold_timeout_o=0.
  - All combinational outputs evaluate to 0 while in reset.
- Jump arbitration, same cycle: int_jump beats ex_jump.
  - sel_flag = int|ex.
  - sel_addr = int_jump_addr_i if int_jump_flag_i, else ex_jump_addr_i.
- Hold level is the max of:
  - div_busy_i → 3.
  - bus_hold_i → 2.
  - state PEND → 2.
- State RUN:
  - If sel_flag && !bus_hold_i: issue the redirect with zero latency (combinational):
    - jump_flag_o=1, jump_addr_o=sel_addr, flush_if_id_o=1, flush_id_ex_o=1.
    - The redirect overrides the div hold for this cycle: hold_o=0.
  - If sel_flag && bus_hold_i:
    - Outputs stay jump_flag_o=0, no flush.
    - pend_addr<=sel_addr; next state PEND.
  - Else: jump_flag_o=0, jump_addr_o=0, no flush, hold_o per the max rule.
- State PEND:
  - While bus_hold_i=1: hold_o≥2; jump/flush outputs 0.
  - A new int_jump_flag_i overwrites pend_addr (interrupt priority). ex_jump_flag_i is ignored, because execute is stalled and the older pending jump wins.
  - First cycle with bus_hold_i=0: replay for exactly one cycle, then next state RUN:
    - jump_flag_o=1, jump_addr_o=pend_addr, both flushes=1, hold_o=0.
    - If int_jump_flag_i is also high in that cycle, int_jump_addr_i is issued instead of pend_addr.
- Bus-hold counter:
  - hold_cnt increments each cycle bus_hold_i=1 and saturates at MAX_HOLD+1.
  - Clears to 0 on any cycle bus_hold_i=0.
  - hold_cnt reaching MAX_HOLD+1 sets hold_timeout_o=1; it stays set until reset.
- Reset mid-PEND: the pending jump is discarded and the controller returns to RUN.
- jump_addr_o is 0 whenever jump_flag_o=0.

Optional Feature:
PIPE_PERF_CNT_EN
- Defined:
  - Adds outputs stall_cycles_o[31:0] and flush_events_o[31:0].
  - stall_cycles_o counts cycles with hold_o≠0.
  - flush_events_o counts cycles with jump_flag_o=1.
  - Both reset to 0 asynchronously and wrap at 2^32.
- Undefined: neither port nor the counters exist; all other behaviour is identical.

Test Plan:
1. Reset → release; ex_jump_flag_i=1, addr=0x0000_0100, no holds → same cycle jump_flag_o=1, jump_addr_o=0x100, both flushes=1, hold_o=0.
2. ex_jump (addr 0x200) and int_jump (addr 0x8) asserted together → jump_addr_o=0x8.
3. bus_hold_i high for 4 cycles; ex_jump (0x300) pulsed in cycle 1 → no redirect during hold, hold_o=2. The cycle bus_hold_i drops: jump_flag_o=1, addr=0x300, flushes=1 for one cycle only.
4. Same as scenario 3, plus int_jump (0x10) in hold cycle 3 → replay addr=0x10; an ex_jump in hold cycle 2 is ignored.
5. div_busy_i=1 for 10 cycles → hold_o=3 throughout, no flush. With bus_hold_i=1 added concurrently, hold_o stays 3.
6. MAX_HOLD=4: bus_hold_i held 6 cycles → hold_timeout_o rises after the 5th hold cycle and stays 1 after release. Asserting rst mid-PEND clears the timeout and suppresses the replay.
